md_unit_scheduler: RTL and testbench
====================================

# md_unit_scheduler

Sequences the multiply/divide unit and its HI/LO register pair for the pipelined MIPS core. It accepts mult/multu/div/divu issue from EX and models the multi-cycle latency with a countdown. It commits results to HI/LO on completion, services mthi/mtlo writes, and raises a stall request to the hazard unit when a HI/LO-touching instruction reaches ID while the unit is occupied. It complements the Tnew logic for mf/mt instructions: those treat HI/LO as ready only when this block is idle.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  EX holds a valid mult/multu/div/divu this cycle
- op  in  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start
- A  in  32  rs operand (also mthi/mtlo data)
- B  in  32  rt operand
- mt_hi  in  1  EX holds mthi; write A to HI
- mt_lo  in  1  EX holds mtlo; write A to LO
- flush  in  1  EX instruction is cancelled this cycle (exception/eret)
- ID_md  in  1  ID instruction is mult/div/mf/mt class
- busy  out  1  operation in flight
- stall_req  out  1  stall ID this cycle
- HI  out  32  HI register
- LO  out  32  LO register

## Operation
- States: IDLE, RUN. Reset → IDLE; busy=0, HI=0, LO=0, counter=0, operand/result latches=0.
- Starting an operation requires IDLE & start & !flush. It latches the result into pending_hi/pending_lo, loads counter with MULT_CYCLES (op[1]=0) or DIV_CYCLES (op[1]=1), and moves to RUN.
- RUN: the counter decrements every cycle. When the counter is 1, it commits pending_hi/lo to HI/LO, clears the counter and returns to IDLE.
- Arithmetic:
  - mult: {HI,LO} = $signed(A)*$signed(B), full 64 bits.
  - multu: same, unsigned.
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Division corner cases:
  - B=0 (div/divu): operation runs its full latency and commits nothing; HI/LO unchanged.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- mt_hi/mt_lo:
  - In IDLE and !flush, the write takes effect at the next edge.
  - Ignored in RUN; the hazard unit guarantees none arrive.
  - If start and mt_* are asserted together, start wins and mt_* is dropped.
- flush only cancels an issue in the same cycle. An operation already in RUN always completes; its instruction has left EX and is architecturally committed.
- stall_req = ID_md & (busy | (start & !flush)), combinational.
- busy is a registered state bit (RUN), not derived from start.
- Counter width: $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).

## Timing
- start sampled at edge E0 → busy=1 for exactly N cycles after E0 (N = MULT_CYCLES or DIV_CYCLES).
- HI/LO update at edge E0+N, same edge busy falls. The new values are visible from that cycle and are never partial.
- stall_req covers the issue cycle plus N busy cycles (N+1 total for a dependent ID_md).
- A new start is accepted in the first cycle busy=0. Back-to-back operations are possible only when no stall intervenes.
- mthi/mtlo: 1-cycle write latency; HI/LO read combinationally from register outputs.
- Asynchronous reset mid-RUN aborts immediately: busy=0, HI=LO=0, pending result discarded; nothing commits after release.
- Outputs HI, LO and busy are glitch-free registered values. stall_req is the only combinational output.

## Test plan
- mult A=0xFFFFFFFE (−2), B=3 at E0 → busy 1 for cycles 1..5. At E0+5 HI=0xFFFFFFFF, LO=0xFFFFFFFA, busy=0.
- multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA after 5 cycles.
- div A=−7, B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0. Then divu 5/0 → HI/LO unchanged, busy still 10 cycles.
- ID_md held high with start at E0 (mult) → stall_req=1 for exactly 6 consecutive cycles, then 0.
- start & flush together → busy stays 0 and HI/LO unchanged. Flush during RUN → result still commits on schedule.
- mthi 0x12345678 while IDLE → HI=0x12345678 next cycle. Assert reset on cycle 3 of a div → busy=0, HI=LO=0 immediately, no later commit.

Source files
------------

// File: rtl/md_unit_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit_scheduler
//  Description : Multiply/divide unit sequencer with HI/LO register pair.
//                Accepts mult/multu/div/divu issue, models fixed latency with
//                a countdown, commits HI/LO on completion, services mthi/mtlo
//                and requests an ID stall while the unit is occupied.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_unit_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        mt_hi,
    input  logic        mt_lo,
    input  logic        flush,
    input  logic        ID_md,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CW         = $clog2(c_MAX_CYCLES + 1);

    localparam logic [c_CW-1:0] c_MULT_LOAD = c_CW'(MULT_CYCLES);
    localparam logic [c_CW-1:0] c_DIV_LOAD  = c_CW'(DIV_CYCLES);
    localparam logic [c_CW-1:0] c_ONE       = c_CW'(1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_next_state;
    logic [c_CW-1:0] r_cnt;
    logic [31:0]     r_hi;
    logic [31:0]     r_lo;
    logic [31:0]     r_pend_hi;
    logic [31:0]     r_pend_lo;
    logic            r_pend_valid;

    logic            w_issue;
    logic            w_done;
    logic            w_mt_ok;

    logic [31:0]     w_a_mag;
    logic [31:0]     w_b_mag;
    logic [63:0]     w_prod;
    logic [31:0]     w_dvd;
    logic [31:0]     w_dvs;
    logic [31:0]     w_quo;
    logic [31:0]     w_rem;
    logic [31:0]     w_res_hi;
    logic [31:0]     w_res_lo;
    logic            w_res_valid;

    // Result datapath: signed division works on magnitudes, then fixes signs
    // so that the INT_MIN / -1 case yields INT_MIN with no overflow trap.
    always_comb begin
        w_a_mag     = A[31] ? (~A + 32'd1) : A;
        w_b_mag     = B[31] ? (~B + 32'd1) : B;
        // Low 64 bits of the product of the sign-extended operands is the
        // exact signed product; zero-extension gives the unsigned one.
        if (op[0]) begin
            w_prod = {32'd0, A} * {32'd0, B};
        end else begin
            w_prod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        end
        w_dvd       = op[0] ? A : w_a_mag;
        w_dvs       = op[0] ? B : w_b_mag;
        // Divisor of zero is steered to one only to keep the divider defined;
        // the result is discarded in that case.
        if (w_dvs == 32'd0) begin
            w_dvs = 32'd1;
        end
        w_quo       = w_dvd / w_dvs;
        w_rem       = w_dvd % w_dvs;
        if (!op[0] && (A[31] ^ B[31])) begin
            w_quo = ~w_quo + 32'd1;
        end
        if (!op[0] && A[31]) begin
            w_rem = ~w_rem + 32'd1;
        end
        w_res_hi    = op[1] ? w_rem : w_prod[63:32];
        w_res_lo    = op[1] ? w_quo : w_prod[31:0];
        w_res_valid = !(op[1] && (B == 32'd0));
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_issue) w_next_state = S_RUN;
            S_RUN:   if (w_done)  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output and control decode
    always_comb begin
        busy      = (r_state == S_RUN);
        w_issue   = (r_state == S_IDLE) && start && !flush;
        w_done    = (r_state == S_RUN) && (r_cnt == c_ONE);
        // start has priority over mthi/mtlo in the same cycle
        w_mt_ok   = (r_state == S_IDLE) && !flush && !start;
        stall_req = ID_md && (busy || (start && !flush));
    end

    // Countdown, pending result latches and the architectural HI/LO pair
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_pend_hi    <= '0;
            r_pend_lo    <= '0;
            r_pend_valid <= 1'b0;
            r_hi         <= '0;
            r_lo         <= '0;
        end else begin
            if (w_issue) begin
                r_cnt        <= op[1] ? c_DIV_LOAD : c_MULT_LOAD;
                r_pend_hi    <= w_res_hi;
                r_pend_lo    <= w_res_lo;
                r_pend_valid <= w_res_valid;
            end else if (w_done) begin
                r_cnt <= '0;
                if (r_pend_valid) begin
                    r_hi <= r_pend_hi;
                    r_lo <= r_pend_lo;
                end
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt - c_ONE;
            end
            if (w_mt_ok && mt_hi) begin
                r_hi <= A;
            end
            if (w_mt_ok && mt_lo) begin
                r_lo <= A;
            end
        end
    end

    assign HI = r_hi;
    assign LO = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_unit_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_unit_scheduler
//  Description : Scoreboard bench for md_unit_scheduler. Expected HI/LO and
//                busy length are queued at issue and compared when busy falls.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit_scheduler;

    localparam int c_MULT_N = 5;
    localparam int c_DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        mt_hi;
    logic        mt_lo;
    logic        flush;
    logic        ID_md;
    logic        busy;
    logic        stall_req;
    logic [31:0] HI;
    logic [31:0] LO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        sb_e;
    int          n_checks;
    int          n_errors;
    int          mon_busy_cnt;
    logic        mon_prev_busy;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit_scheduler #(
        .MULT_CYCLES (c_MULT_N),
        .DIV_CYCLES  (c_DIV_N)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .A         (A),
        .B         (B),
        .mt_hi     (mt_hi),
        .mt_lo     (mt_lo),
        .flush     (flush),
        .ID_md     (ID_md),
        .busy      (busy),
        .stall_req (stall_req),
        .HI        (HI),
        .LO        (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: on each falling edge of busy, pop and compare the scoreboard
    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
            mon_busy_cnt  = 0;
            mon_prev_busy = 1'b0;
        end else begin
            if (busy) begin
                mon_busy_cnt++;
            end else if (mon_prev_busy) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 64'd1, 64'd0);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("commit_hi", {32'd0, HI}, {32'd0, sb_e.hi});
                    check("commit_lo", {32'd0, LO}, {32'd0, sb_e.lo});
                    check("busy_len", 64'(mon_busy_cnt), 64'(sb_e.n));
                end
                mon_busy_cnt = 0;
            end
            mon_prev_busy = busy;
        end
    end

    // Reference result built from SV integer arithmetic on 64-bit values
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el);
        longint          sa;
        longint          sbv;
        longint unsigned ua;
        longint unsigned ub;
        longint          ps;
        longint unsigned pu;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        eh  = m_hi;
        el  = m_lo;
        case (o)
            2'b00: begin ps = sa * sbv; eh = ps[63:32]; el = ps[31:0]; end
            2'b01: begin pu = ua * ub;  eh = pu[63:32]; el = pu[31:0]; end
            2'b10: if (b != 0) begin
                ps = sa / sbv; el = ps[31:0];
                ps = sa % sbv; eh = ps[31:0];
            end
            default: if (b != 0) begin
                pu = ua / ub; el = pu[31:0];
                pu = ua % ub; eh = pu[31:0];
            end
        endcase
    endtask

    task automatic push_exp(input logic [1:0] o, input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        e.hi = eh;
        e.lo = el;
        e.n  = o[1] ? c_DIV_N : c_MULT_N;
        sb_q.push_back(e);
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("sb_drain", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        push_exp(o, eh, el);
        @(posedge clk);
        #1 start = 1'b0;
        wait_drain();
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] eh;
        logic [31:0] el;
        int          scnt;

        n_checks = 0; n_errors = 0;
        mon_busy_cnt = 0; mon_prev_busy = 1'b0;
        m_hi = '0; m_lo = '0;
        reset = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
        mt_hi = 1'b0; mt_lo = 1'b0; flush = 1'b0; ID_md = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_hi", {32'd0, HI}, 64'd0);
        check("rst_lo", {32'd0, LO}, 64'd0);
        check("rst_stall", {63'd0, stall_req}, 64'd0);
        reset = 1'b0;

        // Directed arithmetic cases
        issue(2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        issue(2'b01, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        issue(2'b11, 32'd5, 32'd0, m_hi, m_lo);

        // Stall request spans the issue cycle plus the busy window
        scnt = 0;
        @(negedge clk);
        start = 1'b1; op = 2'b00; A = 32'd7; B = 32'd6; ID_md = 1'b1;
        push_exp(2'b00, 32'd0, 32'd42);
        #1 if (stall_req) scnt++;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (stall_req) scnt++;
        end
        ID_md = 1'b0;
        check("stall_cycles", 64'(scnt), 64'd6);
        wait_drain();

        // Issue cancelled by flush in the same cycle
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b00; A = 32'd9; B = 32'd9;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        check("flush_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        check("flush_hi", {32'd0, HI}, {32'd0, m_hi});
        check("flush_lo", {32'd0, LO}, {32'd0, m_lo});

        // Flush and a stray mtlo during RUN do not disturb the operation
        @(negedge clk);
        start = 1'b1; op = 2'b01; A = 32'd100; B = 32'd3;
        push_exp(2'b01, 32'd0, 32'd300);
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b1; mt_lo = 1'b1; A = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1 flush = 1'b0; mt_lo = 1'b0;
        wait_drain();

        // mthi / mtlo while idle
        @(negedge clk);
        mt_hi = 1'b1; A = 32'h1234_5678;
        @(posedge clk);
        #1 mt_hi = 1'b0;
        check("mthi", {32'd0, HI}, 64'h1234_5678);
        @(negedge clk);
        mt_lo = 1'b1; A = 32'h9ABC_DEF0;
        @(posedge clk);
        #1 mt_lo = 1'b0;
        check("mtlo", {32'd0, LO}, 64'h9ABC_DEF0);
        m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;

        // start beats mthi in the same cycle
        @(negedge clk);
        start = 1'b1; mt_hi = 1'b1; op = 2'b00; A = 32'd2; B = 32'd2;
        push_exp(2'b00, 32'd0, 32'd4);
        @(posedge clk);
        #1 start = 1'b0; mt_hi = 1'b0;
        check("start_wins_hi", {32'd0, HI}, 64'h1234_5678);
        wait_drain();

        // Randomised operations against the integer model
        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (ro[1] && (rb == 0)) rb = 32'd1;
            if (ro == 2'b10 && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
            model(ro, ra, rb, eh, el);
            issue(ro, ra, rb, eh, el);
        end

        // Asynchronous reset in the third busy cycle of a div
        @(negedge clk);
        start = 1'b1; op = 2'b10; A = 32'd100; B = 32'd7;
        push_exp(2'b10, 32'd2, 32'd14);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hi", {32'd0, HI}, 64'd0);
        check("abort_lo", {32'd0, LO}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("post_abort_busy", {63'd0, busy}, 64'd0);
        check("post_abort_hi", {32'd0, HI}, 64'd0);
        check("post_abort_lo", {32'd0, LO}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
